// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions for the operand-fetch stage: instruction
// field positions, immediate-modifier encodings, FSM states and the OF/EX
// payload record.
package simplerisc_pkg;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int RS2ST_MSB    = 25;
    localparam int RS2ST_LSB    = 22;
    localparam int RS1_MSB      = 21;
    localparam int RS1_LSB      = 18;
    localparam int RS2_MSB      = 17;
    localparam int RS2_LSB      = 14;
    localparam int IMM_MSB      = 15;
    localparam int IMM_LSB      = 0;
    localparam int BT_OFF_MSB   = 26;

    // Modifier bits sit at instr[17:16]; bit 16 (unsigned) beats bit 17 (high).
    localparam int IMM_MOD_MSB  = 17;
    localparam int IMM_MOD_LSB  = 16;

    typedef enum logic [1:0] {
        IMM_SIGNED   = 2'b00,
        IMM_UNSIGNED = 2'b01,
        IMM_HIGH     = 2'b10
    } imm_mod_e;

    localparam int RA_IDX_DEFAULT = 15;

    // Payload fields are sized for the widest supported data path; the stage
    // only uses the low XLEN bits of each.
    localparam int PAYLOAD_XLEN_MAX = 64;

    typedef struct packed {
        logic [PAYLOAD_XLEN_MAX-1:0] pc;
        logic [31:0]                 instr;
        logic [PAYLOAD_XLEN_MAX-1:0] immx;
        logic [PAYLOAD_XLEN_MAX-1:0] branchTarget;
        logic [PAYLOAD_XLEN_MAX-1:0] op1;
        logic [PAYLOAD_XLEN_MAX-1:0] op2;
    } of_ex_payload_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } of_state_e;

endpackage

// File: rtl/of_fwd_mux.sv
// Single-source forwarding mux: picks the youngest in-flight producer of the
// source register, and flags a load in EX that the source depends on.
module of_fwd_mux
    import simplerisc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 4
) (
    input  logic [AW-1:0]   src_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            ex_wr_i,
    input  logic            ex_is_ld_i,
    input  logic [AW-1:0]   ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            ma_wr_i,
    input  logic [AW-1:0]   ma_rd_i,
    input  logic [XLEN-1:0] ma_data_i,
    input  logic            rw_wr_i,
    input  logic [AW-1:0]   rw_rd_i,
    input  logic [XLEN-1:0] rw_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            ex_ld_match_o
);

    logic exMatch;
    logic maMatch;
    logic rwMatch;

    assign exMatch       = ex_wr_i && (ex_rd_i == src_i);
    assign maMatch       = ma_wr_i && (ma_rd_i == src_i);
    assign rwMatch       = rw_wr_i && (rw_rd_i == src_i);
    assign ex_ld_match_o = exMatch && ex_is_ld_i;

    // Youngest producer wins; a load in EX has no data yet so it is skipped.
    always_comb begin
        data_o = rf_data_i;
        if (exMatch && !ex_is_ld_i) begin
            data_o = ex_data_i;
        end else if (maMatch) begin
            data_o = ma_data_i;
        end else if (rwMatch) begin
            data_o = rw_data_i;
        end
    end

endmodule

// File: rtl/operand_fetch_pipe.sv
// SimpleRISC operand-fetch stage: decodes immediate and branch target, reads
// and forwards operands, stalls on load-use, and holds the result in a
// one-entry OF/EX register with valid/ready handshake and flush.
module operand_fetch_pipe
    import simplerisc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int RA_IDX = RA_IDX_DEFAULT,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            is_ret,
    input  logic            is_st,
    input  logic            is_ld,
    input  logic            uses_rs1,
    input  logic            uses_rs2,
    input  logic            flush,
    output logic [AW-1:0]   rf_addr1,
    output logic [AW-1:0]   rf_addr2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic            ex_wr,
    input  logic            ma_wr,
    input  logic            rw_wr,
    input  logic [AW-1:0]   ex_rd,
    input  logic [AW-1:0]   ma_rd,
    input  logic [AW-1:0]   rw_rd,
    input  logic [XLEN-1:0] ma_data,
    input  logic [XLEN-1:0] rw_data,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_ld,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_immx,
    output logic [XLEN-1:0] out_branch_target,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [5:0]      out_opcode_ibit
);

    of_state_e      state_q;
    of_ex_payload_t payload_q;
    of_ex_payload_t payload_d;

    logic [AW-1:0]   rs1Idx;
    logic [AW-1:0]   rs2Idx;
    logic [XLEN-1:0] immX;
    logic [XLEN-1:0] branchTarget;
    logic [XLEN-1:0] op1Fwd;
    logic [XLEN-1:0] op2Fwd;
    logic            ldMatch1;
    logic            ldMatch2;
    logic            hazard;
    logic            accept;
    logic [1:0]      immMod;

    // ret implicitly reads the return-address register; stores read rs2 from
    // the destination field.
    assign rs1Idx   = is_ret ? AW'(RA_IDX) : AW'(in_instr[RS1_MSB:RS1_LSB]);
    assign rs2Idx   = is_st ? AW'(in_instr[RS2ST_MSB:RS2ST_LSB]) : AW'(in_instr[RS2_MSB:RS2_LSB]);
    assign rf_addr1 = rs1Idx;
    assign rf_addr2 = rs2Idx;
    assign immMod   = in_instr[IMM_MOD_MSB:IMM_MOD_LSB];

    // Immediate extension; the unsigned modifier has priority over the high one.
    always_comb begin
        immX = XLEN'($signed(in_instr[IMM_MSB:IMM_LSB]));
        if (immMod[0]) begin
            immX = XLEN'(in_instr[IMM_MSB:IMM_LSB]);
        end else if (immMod[1]) begin
            immX = XLEN'({in_instr[IMM_MSB:IMM_LSB], 16'h0000});
        end
    end

    // Word offset is sign-extended after the shift; the add wraps at XLEN.
    assign branchTarget = in_pc + XLEN'($signed({in_instr[BT_OFF_MSB:0], 2'b00}));

    of_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd1 (
        .src_i         (rs1Idx),
        .rf_data_i     (rf_data1),
        .ex_wr_i       (ex_wr),
        .ex_is_ld_i    (ex_is_ld),
        .ex_rd_i       (ex_rd),
        .ex_data_i     (ex_data),
        .ma_wr_i       (ma_wr),
        .ma_rd_i       (ma_rd),
        .ma_data_i     (ma_data),
        .rw_wr_i       (rw_wr),
        .rw_rd_i       (rw_rd),
        .rw_data_i     (rw_data),
        .data_o        (op1Fwd),
        .ex_ld_match_o (ldMatch1)
    );

    of_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd2 (
        .src_i         (rs2Idx),
        .rf_data_i     (rf_data2),
        .ex_wr_i       (ex_wr),
        .ex_is_ld_i    (ex_is_ld),
        .ex_rd_i       (ex_rd),
        .ex_data_i     (ex_data),
        .ma_wr_i       (ma_wr),
        .ma_rd_i       (ma_rd),
        .ma_data_i     (ma_data),
        .rw_wr_i       (rw_wr),
        .rw_rd_i       (rw_rd),
        .rw_data_i     (rw_data),
        .data_o        (op2Fwd),
        .ex_ld_match_o (ldMatch2)
    );

    // Only sources the instruction actually reads can cause a load-use stall.
    assign hazard    = in_valid && ((uses_rs1 && ldMatch1) || (uses_rs2 && ldMatch2));
    assign out_valid = (state_q == FULL);
    assign in_ready  = !reset && !hazard && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;

    // Assemble the next payload from the decoded and forwarded values.
    always_comb begin
        payload_d              = '0;
        payload_d.pc           = PAYLOAD_XLEN_MAX'(in_pc);
        payload_d.instr        = in_instr;
        payload_d.immx         = PAYLOAD_XLEN_MAX'(immX);
        payload_d.branchTarget = PAYLOAD_XLEN_MAX'(branchTarget);
        payload_d.op1          = PAYLOAD_XLEN_MAX'(op1Fwd);
        payload_d.op2          = PAYLOAD_XLEN_MAX'(op2Fwd);
    end

    // EMPTY/FULL entry state: flush beats accept, accept beats consume; the
    // payload only changes on accept so it stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            payload_q <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else if (accept) begin
            state_q   <= FULL;
            payload_q <= payload_d;
        end else if ((state_q == FULL) && out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign out_pc            = payload_q.pc[XLEN-1:0];
    assign out_instr         = payload_q.instr;
    assign out_immx          = payload_q.immx[XLEN-1:0];
    assign out_branch_target = payload_q.branchTarget[XLEN-1:0];
    assign out_op1           = payload_q.op1[XLEN-1:0];
    assign out_op2           = payload_q.op2[XLEN-1:0];
    assign out_opcode_ibit   = payload_q.instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Directed bench for operand_fetch_pipe: a vector table for decode and
// forwarding, plus hand-written reset, load-use, backpressure and flush runs.
module tb_operand_fetch_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        is_ret;
    logic        is_st;
    logic        is_ld;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        flush;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        ex_wr;
    logic        ma_wr;
    logic        rw_wr;
    logic [3:0]  ex_rd;
    logic [3:0]  ma_rd;
    logic [3:0]  rw_rd;
    logic [31:0] ma_data;
    logic [31:0] rw_data;
    logic [31:0] ex_data;
    logic        ex_is_ld;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_immx;
    logic [31:0] out_branch_target;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [5:0]  out_opcode_ibit;

    int passCount;
    int totalCount;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        isRet;
        logic        isSt;
        logic        usesRs1;
        logic        usesRs2;
        logic        exWr;
        logic        exIsLd;
        logic        maWr;
        logic        rwWr;
        logic [3:0]  exRd;
        logic [3:0]  maRd;
        logic [3:0]  rwRd;
        logic [31:0] exData;
        logic [31:0] maData;
        logic [31:0] rwData;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [3:0]  expAddr1;
        logic [3:0]  expAddr2;
        logic [31:0] expImm;
        logic [31:0] expTgt;
        logic [31:0] expOp1;
        logic [31:0] expOp2;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    operand_fetch_pipe dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pc             (in_pc),
        .in_instr          (in_instr),
        .is_ret            (is_ret),
        .is_st             (is_st),
        .is_ld             (is_ld),
        .uses_rs1          (uses_rs1),
        .uses_rs2          (uses_rs2),
        .flush             (flush),
        .rf_addr1          (rf_addr1),
        .rf_addr2          (rf_addr2),
        .rf_data1          (rf_data1),
        .rf_data2          (rf_data2),
        .ex_wr             (ex_wr),
        .ma_wr             (ma_wr),
        .rw_wr             (rw_wr),
        .ex_rd             (ex_rd),
        .ma_rd             (ma_rd),
        .rw_rd             (rw_rd),
        .ma_data           (ma_data),
        .rw_data           (rw_data),
        .ex_data           (ex_data),
        .ex_is_ld          (ex_is_ld),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_instr         (out_instr),
        .out_immx          (out_immx),
        .out_branch_target (out_branch_target),
        .out_op1           (out_op1),
        .out_op2           (out_op2),
        .out_opcode_ibit   (out_opcode_ibit)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        is_ret    = 1'b0;
        is_st     = 1'b0;
        is_ld     = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        flush     = 1'b0;
        rf_data1  = 32'h1111_1111;
        rf_data2  = 32'h2222_2222;
        ex_wr     = 1'b0;
        ma_wr     = 1'b0;
        rw_wr     = 1'b0;
        ex_rd     = '0;
        ma_rd     = '0;
        rw_rd     = '0;
        ex_data   = '0;
        ma_data   = '0;
        rw_data   = '0;
        ex_is_ld  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = v.pc;
        is_ret   = v.isRet;
        is_st    = v.isSt;
        uses_rs1 = v.usesRs1;
        uses_rs2 = v.usesRs2;
        ex_wr    = v.exWr;
        ex_is_ld = v.exIsLd;
        ma_wr    = v.maWr;
        rw_wr    = v.rwWr;
        ex_rd    = v.exRd;
        ma_rd    = v.maRd;
        rw_rd    = v.rwRd;
        ex_data  = v.exData;
        ma_data  = v.maData;
        rw_data  = v.rwData;
        rf_data1 = v.rf1;
        rf_data2 = v.rf2;
        #1;
    endtask

    initial begin
        vec_t v;
        passCount  = 0;
        totalCount = 0;

        // imm bit16, bit17, neither; then the branch wrap case
        vecs[0] = '{instr: 32'h0001_8001, pc: 32'h100, usesRs1: 1'b1, usesRs2: 1'b1,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd0, expAddr2: 4'd6,
                    expImm: 32'h0000_8001, expTgt: 32'h0006_0104,
                    expOp1: 32'h1111_1111, expOp2: 32'h2222_2222, default: '0};
        vecs[1] = '{instr: 32'h0002_8001, pc: 32'h100, usesRs1: 1'b1, usesRs2: 1'b1,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd0, expAddr2: 4'hA,
                    expImm: 32'h8001_0000, expTgt: 32'h000A_0104,
                    expOp1: 32'h1111_1111, expOp2: 32'h2222_2222, default: '0};
        vecs[2] = '{instr: 32'h0000_8001, pc: 32'h100, usesRs1: 1'b1, usesRs2: 1'b1,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd0, expAddr2: 4'd2,
                    expImm: 32'hFFFF_8001, expTgt: 32'h0002_0104,
                    expOp1: 32'h1111_1111, expOp2: 32'h2222_2222, default: '0};
        vecs[3] = '{instr: 32'h4FFF_FFFF, pc: 32'h100, usesRs1: 1'b1, usesRs2: 1'b1,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'hF, expAddr2: 4'hF,
                    expImm: 32'h0000_FFFF, expTgt: 32'h0000_00FC,
                    expOp1: 32'h1111_1111, expOp2: 32'h2222_2222, default: '0};
        // ret reads r15 even though the rs1 field says 3 (and RW holds r3)
        vecs[4] = '{instr: 32'h000C_0000, pc: 32'h200, isRet: 1'b1, usesRs1: 1'b1,
                    rwWr: 1'b1, rwRd: 4'd3, rwData: 32'hC,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'hF, expAddr2: 4'd0,
                    expImm: 32'h0, expTgt: 32'h0030_0200,
                    expOp1: 32'h1111_1111, expOp2: 32'h2222_2222, default: '0};
        // forwarding priority EX > MA > RW on rs1 = 3
        vecs[5] = '{instr: 32'h000C_0000, pc: 32'h200, usesRs1: 1'b1,
                    exWr: 1'b1, maWr: 1'b1, rwWr: 1'b1, exRd: 4'd3, maRd: 4'd3, rwRd: 4'd3,
                    exData: 32'hA, maData: 32'hB, rwData: 32'hC,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd3, expAddr2: 4'd0,
                    expImm: 32'h0, expTgt: 32'h0030_0200,
                    expOp1: 32'hA, expOp2: 32'h2222_2222, default: '0};
        vecs[6] = '{instr: 32'h000C_0000, pc: 32'h200, usesRs1: 1'b1,
                    maWr: 1'b1, rwWr: 1'b1, exRd: 4'd3, maRd: 4'd3, rwRd: 4'd3,
                    exData: 32'hA, maData: 32'hB, rwData: 32'hC,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd3, expAddr2: 4'd0,
                    expImm: 32'h0, expTgt: 32'h0030_0200,
                    expOp1: 32'hB, expOp2: 32'h2222_2222, default: '0};
        vecs[7] = '{instr: 32'h000C_0000, pc: 32'h200, usesRs1: 1'b1,
                    rwWr: 1'b1, exRd: 4'd3, maRd: 4'd3, rwRd: 4'd3,
                    exData: 32'hA, maData: 32'hB, rwData: 32'hC,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd3, expAddr2: 4'd0,
                    expImm: 32'h0, expTgt: 32'h0030_0200,
                    expOp1: 32'hC, expOp2: 32'h2222_2222, default: '0};
        // store reads rs2 from instr[25:22] = 5, forwarded from MA
        vecs[8] = '{instr: 32'h0140_0000, pc: 32'h300, isSt: 1'b1, usesRs1: 1'b1, usesRs2: 1'b1,
                    maWr: 1'b1, maRd: 4'd5, maData: 32'hB,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd0, expAddr2: 4'd5,
                    expImm: 32'h0, expTgt: 32'h0500_0300,
                    expOp1: 32'h1111_1111, expOp2: 32'hB, default: '0};
        // load in EX matches rs1 but rs1 is unused: no stall, EX data skipped
        vecs[9] = '{instr: 32'h000C_0000, pc: 32'h400, usesRs2: 1'b1,
                    exWr: 1'b1, exIsLd: 1'b1, maWr: 1'b1, exRd: 4'd3, maRd: 4'd3,
                    exData: 32'hA, maData: 32'hB,
                    rf1: 32'h1111_1111, rf2: 32'h2222_2222, expAddr1: 4'd3, expAddr2: 4'd0,
                    expImm: 32'h0, expTgt: 32'h0030_0400,
                    expOp1: 32'hB, expOp2: 32'h2222_2222, default: '0};

        // Reset held for two cycles with a valid input waiting
        clearInputs();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h40;
        in_instr = 32'h0000_8001;
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
            checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
            checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
            checkOutput("rst_out_immx", 64'(out_immx), 64'd0);
            checkOutput("rst_out_op1", 64'(out_op1), 64'd0);
        end
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("first_accept_valid", 64'(out_valid), 64'd1);
        checkOutput("first_accept_pc", 64'(out_pc), 64'h40);
        checkOutput("first_accept_immx", 64'(out_immx), 64'hFFFF_8001);

        // Table: one accept per cycle with EX always ready
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            applyStimulus(v);
            checkOutput($sformatf("v%0d_rf_addr1", i), 64'(rf_addr1), 64'(v.expAddr1));
            checkOutput($sformatf("v%0d_rf_addr2", i), 64'(rf_addr2), 64'(v.expAddr2));
            checkOutput($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            tick();
            checkOutput($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("v%0d_out_pc", i), 64'(out_pc), 64'(v.pc));
            checkOutput($sformatf("v%0d_out_instr", i), 64'(out_instr), 64'(v.instr));
            checkOutput($sformatf("v%0d_opcode", i), 64'(out_opcode_ibit), 64'(v.instr[31:26]));
            checkOutput($sformatf("v%0d_immx", i), 64'(out_immx), 64'(v.expImm));
            checkOutput($sformatf("v%0d_target", i), 64'(out_branch_target), 64'(v.expTgt));
            checkOutput($sformatf("v%0d_op1", i), 64'(out_op1), 64'(v.expOp1));
            checkOutput($sformatf("v%0d_op2", i), 64'(out_op2), 64'(v.expOp2));
        end

        // Load-use on rs2 = 5: one stall cycle, one bubble, then MA forward
        clearInputs();
        in_valid = 1'b1;
        in_pc    = 32'h500;
        in_instr = 32'h0001_4000;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ex_wr    = 1'b1;
        ex_is_ld = 1'b1;
        ex_rd    = 4'd5;
        ex_data  = 32'hDEAD;
        #1;
        checkOutput("ld_stall_in_ready", 64'(in_ready), 64'd0);
        checkOutput("ld_stall_rf_addr2", 64'(rf_addr2), 64'd5);
        tick();
        checkOutput("ld_bubble_valid", 64'(out_valid), 64'd0);
        ex_wr    = 1'b0;
        ex_is_ld = 1'b0;
        ma_wr    = 1'b1;
        ma_rd    = 4'd5;
        ma_data  = 32'h5A5A;
        #1;
        checkOutput("ld_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("ld_accept_valid", 64'(out_valid), 64'd1);
        checkOutput("ld_accept_pc", 64'(out_pc), 64'h500);
        checkOutput("ld_accept_op2", 64'(out_op2), 64'h5A5A);

        // Backpressure: entry A holds for three cycles while B waits
        clearInputs();
        in_valid = 1'b1;
        in_pc    = 32'h600;
        in_instr = 32'h0000_8001;
        tick();
        checkOutput("bp_a_pc", 64'(out_pc), 64'h600);
        in_pc     = 32'h700;
        in_instr  = 32'h0001_8001;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
            tick();
            checkOutput($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bp%0d_pc", c), 64'(out_pc), 64'h600);
            checkOutput($sformatf("bp%0d_immx", c), 64'(out_immx), 64'hFFFF_8001);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("bp_b_pc", 64'(out_pc), 64'h700);
        checkOutput("bp_b_immx", 64'(out_immx), 64'h0000_8001);

        // Flush with a valid input: entry killed and input dropped
        in_pc    = 32'h800;
        in_instr = 32'h0000_0000;
        flush    = 1'b1;
        #1;
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("flush_dropped_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/operand_fetch_pipe.md
# operand_fetch_pipe

Registered, parametrised operand-fetch stage for the SimpleRISC pipeline, sitting between instruction fetch and execute. It decodes immediates and branch targets, reads the register file, and resolves RAW hazards by forwarding from EX/MA/RW or stalling on load-use. Results are presented through a one-entry OF/EX pipeline register with a valid/ready handshake and flush. Compared with the purely combinational predecessor, it corrects the `ret` source register to `ra`, and both data width and register count are parameters.

## Interface
- `XLEN`, 32: data-path width; immediate and branch target are extended to `XLEN`.
- `NREG`, 16: architectural register count.
- `RA_IDX`, 15: index of the return-address register, read as rs1 on `ret`.
- `AW`, `$clog2(NREG)`: register index width. Derived; do not override.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: `in_pc` and `in_instr` are valid this cycle.
- `in_ready` out 1: the stage accepts this cycle.
- `in_pc` in `XLEN`: instruction PC.
- `in_instr` in 32: instruction word.
- `is_ret`, `is_st`, `is_ld` in 1: decoder flags for `in_instr`.
- `uses_rs1`, `uses_rs2` in 1: decoder flags saying the source is actually read.
- `flush` in 1: kill the registered entry and drop any input this cycle.
- `rf_addr1`, `rf_addr2` out `AW`: register-file read addresses. Combinational from input.
- `rf_data1`, `rf_data2` in `XLEN`: register-file read data, same cycle as the addresses.
- `ex_wr`, `ma_wr`, `rw_wr` in 1: the downstream stage will write `*_rd`.
- `ex_rd`, `ma_rd`, `rw_rd` in `AW`: destination register of each downstream stage.
- `ma_data`, `rw_data` in `XLEN`: forwardable result of MA and RW.
- `ex_data` in `XLEN`: forwardable ALU result of EX. Invalid when `ex_is_ld`.
- `ex_is_ld` in 1: the EX instruction is a load.
- `out_valid` out 1: the OF/EX register holds an instruction.
- `out_ready` in 1: EX consumes the entry this cycle.
- `out_pc`, `out_instr`, `out_immx`, `out_branch_target`, `out_op1`, `out_op2`: registered payload. `out_instr` is 32 bits; the rest are `XLEN`.
- `out_opcode_ibit` out 6: registered `instr[31:26]`.

## Operation
- Source selection:
  - rs1 = `is_ret` ? `RA_IDX` : `instr[21:18]`.
  - rs2 = `is_st` ? `instr[25:22]` : `instr[17:14]`.
  - Indices are zero-extended or truncated to `AW`.
- Immediate, decided by `instr[17:16]`:
  - `instr[16]` = 1: zero-extend `instr[15:0]`. Bit 16 has priority over bit 17.
  - else `instr[17]` = 1: `instr[15:0]` shifted left by 16, zero-filled.
  - otherwise: sign-extend `instr[15:0]`.
  - Result is truncated to `XLEN` if `XLEN` < 32.
- Branch target = `in_pc` + (sign-extended `instr[26:0]` << 2), modulo 2^`XLEN`; overflow wraps silently.
- Forwarding per used source, highest priority first:
  - EX match and not `ex_is_ld`: `ex_data`.
  - MA match: `ma_data`.
  - RW match: `rw_data`.
  - otherwise: `rf_data`.
  - A "match" means `*_wr` is set and `*_rd` equals the source index.
- Load-use hazard: `in_valid` && `ex_wr` && `ex_is_ld` && `ex_rd` matches a used source.
- Handshake:
  - `in_ready` = !hazard && (!`out_valid` || `out_ready`) && !`flush`.
  - Accept = `in_valid` && `in_ready`.
- Register update each cycle:
  - `flush`: `out_valid` goes to 0. Flush wins over accept and over hold.
  - Accept: load the payload and set `out_valid` to 1.
  - `out_valid` && `out_ready` without accept: `out_valid` goes to 0 and the payload holds.
  - Otherwise: hold.
- Implicit two-state FSM, EMPTY and FULL. EMPTY goes to FULL on accept; FULL goes to EMPTY on consume-without-accept or on flush.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle while `out_ready` is 1 and there is no hazard.
- Reset: `out_valid` is 0 and every `out_*` payload is 0. `in_ready` follows its combinational equation once `reset` is low.
- Reset mid-stall or mid-hold discards the entry; no partial state survives.
- A stall inserts a bubble (`out_valid` = 0) if EX consumes the current entry; it holds `in_ready` low until the load leaves EX.
- The payload must be stable while `out_valid` && !`out_ready`.

## Structure
- Shared package `simplerisc_pkg`:
  - Instruction field positions.
  - Default `RA_IDX`.
  - Immediate-modifier encodings.
  - The OF/EX payload struct type.
- One sub-module, `of_fwd_mux`: a single-source forwarding priority mux, instantiated twice.
- Immediate and branch-target logic stay inline.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid` = 1. All outputs are 0; the first accept happens on the first cycle after reset deasserts.
- Immediate modes: `instr[15:0]` = 0x8001.
  - Bit 16 set: `out_immx` = 0x00008001.
  - Bit 17 set: `out_immx` = 0x80010000.
  - Neither bit set: `out_immx` = 0xFFFF8001.
- Branch and `ret`:
  - `in_pc` = 0x100 with offset field 0x7FFFFFF: `out_branch_target` = 0xFC.
  - `is_ret`: `rf_addr1` = 15 and `out_op1` = `rf_data1`.
- Forward priority: rs1 = 3, `ex_rd` = `ma_rd` = `rw_rd` = 3, all `*_wr` = 1, `ex_data` = 0xA, `ma_data` = 0xB. `out_op1` = 0xA. Repeat with `ex_wr` = 0: `out_op1` = 0xB.
- Load-use: `ex_is_ld` with `ex_rd` = 5 and an incoming instruction using rs2 = 5. `in_ready` = 0 for exactly the cycles the load stays in EX, one bubble appears downstream, and the instruction is then accepted with the forwarded MA data.
- Backpressure and flush:
  - `out_ready` = 0 for 3 cycles: the payload holds and `in_ready` = 0.
  - `flush` together with `in_valid`: `out_valid` = 0 on the next cycle and the input is dropped, not accepted.
